// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx arbiter slice.
package uart_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward
// from last+1, wrapping modulo NUM_REQ (correct for non-power-of-2 counts).
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               any_req,
  output logic [IDX_W-1:0]   pick
);

  logic [IDX_W-1:0] cand;
  logic             found;

  assign any_req = |req;

  always_comb begin
    cand  = last;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between AXI-Stream
// requesters. Optional macro UART_ARB_BURST_LIMIT_EN caps beats per grant at MAX_BURST.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]            s_axis_tvalid,
  input  logic [NUM_REQ-1:0]            s_axis_tlast,
  output logic [NUM_REQ-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDX_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
  logic                  any_req;
  logic [IDX_W-1:0]      pick;
  logic                  owner_valid;
  logic                  beat_fire;
  logic                  grant_rel;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (s_axis_tvalid),
    .last    (last_q),
    .any_req (any_req),
    .pick    (pick)
  );

  assign owner_valid = s_axis_tvalid[grant_q];
  assign beat_fire   = (state_q == ARB_LOCKED) && owner_valid && m_axis_tready;

`ifdef UART_ARB_BURST_LIMIT_EN
  // The beat that brings beat_cnt to MAX_BURST releases exactly like tlast.
  assign grant_rel = s_axis_tlast[grant_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1));
`else
  assign grant_rel = s_axis_tlast[grant_q];
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    beat_cnt_d    = beat_cnt_q;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    busy          = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        busy                   = 1'b1;
        m_axis_tdata           = req_data[grant_q];
        m_axis_tvalid          = owner_valid;
        s_axis_tready[grant_q] = m_axis_tready;
        if (beat_fire) begin
          if (grant_rel) begin
            last_d     = grant_q;
            beat_cnt_d = '0;
            state_d    = ARB_IDLE;
          end else if (beat_cnt_q != CNT_W'(MAX_BURST)) begin
            // Saturates so over-long packets cannot wrap the counter.
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; burst-limit scenario
// runs only when UART_ARB_BURST_LIMIT_EN is defined.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
`ifdef UART_ARB_BURST_LIMIT_EN
  localparam int MB = 4;
`else
  localparam int MB = 16;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*DW-1:0] s_tdata;
  logic [NR-1:0]    s_tvalid;
  logic [NR-1:0]    s_tlast;
  logic [NR-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic [1:0]       grant_id;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] val);
    s_tdata[idx*DW +: DW] = val;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    s_tvalid = 4'hF;
    m_tready = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_mvalid got %0b exp 0", m_tvalid); end
    checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_sready got %b exp 0000", s_tready); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    checks++; if (m_tdata !== 8'h00) begin errors++; $display("FAIL reset_mdata got %h exp 00", m_tdata); end
    tick();
    tick();
    checks++; if (busy !== 1'b0 || s_tready !== 4'b0000) begin
      errors++; $display("FAIL reset_hold busy=%0b sready=%b exp 0/0000", busy, s_tready);
    end
    clear_inputs();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  // Requester 2 sends 0x41,0x42,0x43; requester 0 is the default first winner only if valid.
  task automatic test_single_packet();
    s_tvalid = 4'b0100;
    set_data(2, 8'h41);
    m_tready = 1'b1;
    #1;
    checks++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_idle mvalid=%0b busy=%0b exp 0/0", m_tvalid, busy);
    end
    tick();
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant got %0d exp 2", grant_id); end
    checks++; if (s_tready !== 4'b0100) begin errors++; $display("FAIL single_sready got %b exp 0100", s_tready); end
    checks++; if (m_tdata !== 8'h41 || m_tvalid !== 1'b1) begin
      errors++; $display("FAIL single_beat0 got %h/%0b exp 41/1", m_tdata, m_tvalid);
    end
    tick();
    set_data(2, 8'h42);
    #1;
    checks++; if (m_tdata !== 8'h42) begin errors++; $display("FAIL single_beat1 got %h exp 42", m_tdata); end
    tick();
    set_data(2, 8'h43);
    s_tlast = 4'b0100;
    #1;
    checks++; if (m_tdata !== 8'h43 || busy !== 1'b1) begin
      errors++; $display("FAIL single_beat2 got %h busy=%0b exp 43/1", m_tdata, busy);
    end
    tick();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL single_release busy=%0b mvalid=%0b exp 0/0", busy, m_tvalid);
    end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_hold got %0d exp 2", grant_id); end
    $display("test_single_packet req=2 beats=3");
  endtask

  task automatic test_round_robin();
    int exp;
    for (int i = 0; i < NR; i++) set_data(i, 8'(16 + i));
    s_tvalid = 4'hF;
    s_tlast  = 4'hF;
    m_tready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp = k % NR;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_gap%0d busy=%0b exp 0", k, busy); end
      tick();
      checks++; if (grant_id !== 2'(exp)) begin
        errors++; $display("FAIL rr_grant%0d got %0d exp %0d", k, grant_id, exp);
      end
      checks++; if (m_tdata !== 8'(16 + exp) || s_tready !== 4'(1 << exp)) begin
        errors++; $display("FAIL rr_beat%0d data=%h sready=%b exp %h/%b", k, m_tdata, s_tready, 8'(16 + exp), 4'(1 << exp));
      end
      $display("rr packet k=%0d grant=%0d", k, grant_id);
      tick();
    end
    clear_inputs();
  endtask

  // Requester 1 holds the grant through a tvalid bubble while 0 and 3 wait.
  task automatic test_no_preempt();
    s_tvalid = 4'b0010;
    s_tlast  = 4'b0000;
    set_data(1, 8'hA0);
    m_tready = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd1 || m_tdata !== 8'hA0) begin
      errors++; $display("FAIL np_start grant=%0d data=%h exp 1/a0", grant_id, m_tdata);
    end
    tick();
    set_data(1, 8'hA1);
    tick();
    s_tvalid = 4'b1011;
    s_tlast  = 4'b1001;
    set_data(0, 8'hC0);
    set_data(3, 8'hC3);
    set_data(1, 8'hA2);
    #1;
    checks++; if (grant_id !== 2'd1 || s_tready !== 4'b0010 || m_tdata !== 8'hA2) begin
      errors++; $display("FAIL np_contend grant=%0d sready=%b data=%h exp 1/0010/a2", grant_id, s_tready, m_tdata);
    end
    tick();
    s_tvalid = 4'b1001;
    #1;
    checks++; if (m_tvalid !== 1'b0 || busy !== 1'b1 || s_tready !== 4'b0010) begin
      errors++; $display("FAIL np_bubble mvalid=%0b busy=%0b sready=%b exp 0/1/0010", m_tvalid, busy, s_tready);
    end
    tick();
    s_tvalid = 4'b1011;
    s_tlast  = 4'b1011;
    set_data(1, 8'hA3);
    #1;
    checks++; if (m_tdata !== 8'hA3 || m_tvalid !== 1'b1 || grant_id !== 2'd1) begin
      errors++; $display("FAIL np_last data=%h mvalid=%0b grant=%0d exp a3/1/1", m_tdata, m_tvalid, grant_id);
    end
    tick();
    s_tvalid = 4'b1001;
    s_tlast  = 4'b1001;
    #1;
    checks++; if (busy !== 1'b0 || s_tready !== 4'b0000) begin
      errors++; $display("FAIL np_gap busy=%0b sready=%b exp 0/0000", busy, s_tready);
    end
    tick();
    checks++; if (grant_id !== 2'd3 || m_tdata !== 8'hC3) begin
      errors++; $display("FAIL np_next3 grant=%0d data=%h exp 3/c3", grant_id, m_tdata);
    end
    tick();
    s_tvalid = 4'b0001;
    tick();
    checks++; if (grant_id !== 2'd0 || m_tdata !== 8'hC0) begin
      errors++; $display("FAIL np_next0 grant=%0d data=%h exp 0/c0", grant_id, m_tdata);
    end
    tick();
    clear_inputs();
    $display("test_no_preempt order 1,3,0");
  endtask

  task automatic test_backpressure();
    logic [5:0] rpat;
    int beat;
    int acc;
    rpat     = 6'b111001;
    beat     = 0;
    acc      = 0;
    s_tvalid = 4'b0001;
    s_tlast  = 4'b0000;
    set_data(0, 8'hD0);
    m_tready = 1'b0;
    tick();
    for (int c = 0; c < 10 && beat < 4; c++) begin
      m_tready = (c < 6) ? rpat[c] : 1'b1;
      set_data(0, 8'(8'hD0 + beat));
      s_tlast = (beat == 3) ? 4'b0001 : 4'b0000;
      #1;
      checks++; if (m_tdata !== 8'(8'hD0 + beat) || m_tvalid !== 1'b1) begin
        errors++; $display("FAIL bp_data c=%0d got %h/%0b exp %h/1", c, m_tdata, m_tvalid, 8'(8'hD0 + beat));
      end
      checks++; if (s_tready !== {3'b000, m_tready}) begin
        errors++; $display("FAIL bp_sready c=%0d got %b exp %b", c, s_tready, {3'b000, m_tready});
      end
      if (m_tvalid && m_tready) acc++;
      if (m_tready) beat++;
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (acc !== 4 || beat !== 4) begin
      errors++; $display("FAIL bp_count accepted=%0d sent=%0d exp 4/4", acc, beat);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release busy=%0b exp 0", busy); end
    $display("test_backpressure beats=%0d", acc);
  endtask

  task automatic test_reset_midpacket();
    s_tvalid = 4'b0100;
    s_tlast  = 4'b0000;
    set_data(2, 8'h61);
    m_tready = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL rm_grant got %0d exp 2", grant_id); end
    tick();
    set_data(2, 8'h62);
    #1;
    checks++; if (m_tdata !== 8'h62) begin errors++; $display("FAIL rm_beat1 got %h exp 62", m_tdata); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL rm_async mvalid=%0b sready=%b busy=%0b exp 0/0000/0", m_tvalid, s_tready, busy);
    end
    checks++; if (grant_id !== 2'd0 || m_tdata !== 8'h00) begin
      errors++; $display("FAIL rm_values grant=%0d data=%h exp 0/00", grant_id, m_tdata);
    end
    tick();
    checks++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL rm_next busy=%0b mvalid=%0b exp 0/0", busy, m_tvalid);
    end
    s_tvalid = 4'b0101;
    s_tlast  = 4'b0001;
    set_data(0, 8'h70);
    rst_n = 1'b1;
    tick();
    checks++; if (grant_id !== 2'd0 || m_tdata !== 8'h70) begin
      errors++; $display("FAIL rm_first grant=%0d data=%h exp 0/70", grant_id, m_tdata);
    end
    tick();
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_done busy=%0b exp 0", busy); end
    $display("test_reset_midpacket first winner=0");
  endtask

`ifdef UART_ARB_BURST_LIMIT_EN
  task automatic test_burst_limit();
    int seg_g [5];
    int seg_n [5];
    int b0;
    seg_g = '{0, 1, 0, 1, 0};
    seg_n = '{4, 1, 4, 1, 2};
    b0 = 0;
    set_data(1, 8'h77);
    s_tvalid = 4'b0011;
    s_tlast  = 4'b0010;
    m_tready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      set_data(0, 8'(8'h50 + b0));
      s_tlast[0] = (b0 == 9);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bl_gap%0d busy=%0b exp 0", s, busy); end
      tick();
      for (int j = 0; j < seg_n[s]; j++) begin
        set_data(0, 8'(8'h50 + b0));
        s_tlast[0] = (b0 == 9);
        #1;
        checks++; if (grant_id !== 2'(seg_g[s])) begin
          errors++; $display("FAIL bl_grant s=%0d j=%0d got %0d exp %0d", s, j, grant_id, seg_g[s]);
        end
        checks++; if (m_tdata !== ((seg_g[s] == 0) ? 8'(8'h50 + b0) : 8'h77)) begin
          errors++; $display("FAIL bl_data s=%0d j=%0d got %h", s, j, m_tdata);
        end
        if (seg_g[s] == 0) b0++;
        tick();
      end
      $display("bl grant=%0d beats=%0d", seg_g[s], seg_n[s]);
    end
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0 || b0 !== 10) begin
      errors++; $display("FAIL bl_end busy=%0b sent=%0d exp 0/10", busy, b0);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_packet();
    apply_reset();
    test_round_robin();
    test_no_preempt();
    test_backpressure();
    test_reset_midpacket();
`ifdef UART_ARB_BURST_LIMIT_EN
    apply_reset();
    test_burst_limit();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
